profile_report_streamer: RTL and testbench



---
 rtl/profile_report_streamer.sv | 207 ++++++++++++++++++++
 tb/tb_profile_report_streamer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/profile_report_streamer.sv
// profile_report_streamer
// Captures the profiler's category counters into shadow registers on a
// snapshot request and streams them as a framed byte sequence over a
// valid/ready byte interface:
//   HEADER_BYTE, NUM_COUNTERS, counter[0..N-1] (4 bytes each, MSB first)
//   [, checksum]
// Optional feature macro: PROFILER_REPORT_CHECKSUM_EN. When defined, a
// trailing checksum byte is appended. The checksum is the 8-bit sum of the
// count byte and all data bytes.
module profile_report_streamer #(
    parameter int          NUM_COUNTERS = 11,
    parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       snapshot_req,
    input  logic [NUM_COUNTERS*32-1:0] counters_flat,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic [15:0]                frame_count,
    output logic [7:0]                 overrun_count
);

    localparam int NUM_BYTES = 4 * NUM_COUNTERS;
    localparam int IDX_W     = $clog2(NUM_BYTES);
    localparam int WORD_W    = IDX_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES - 1);
    localparam logic [7:0]       COUNT_BYTE = 8'(NUM_COUNTERS);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        COUNT,
        DATA
`ifdef PROFILER_REPORT_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   byte_idx_reg, byte_idx_next;
    logic [7:0]         tx_data_reg, tx_data_next;
    logic               tx_valid_reg, tx_valid_next;
    logic [15:0]        frame_count_reg;
    logic [7:0]         overrun_count_reg;
    logic [31:0]        shadow_reg [NUM_COUNTERS];
`ifdef PROFILER_REPORT_CHECKSUM_EN
    logic [7:0]         csum_reg, csum_next;
`endif

    logic               handshake;
    logic               load_shadow;
    logic               frame_done;
    logic [IDX_W-1:0]   sel_idx;
    logic [WORD_W-1:0]  sel_word_idx;
    logic [31:0]        sel_word;
    logic [7:0]         sel_byte;

    assign handshake     = tx_valid_reg & tx_ready;
    assign busy          = (state_reg != IDLE);
    assign tx_data       = tx_data_reg;
    assign tx_valid      = tx_valid_reg;
    assign frame_count   = frame_count_reg;
    assign overrun_count = overrun_count_reg;

    // Shadow capture: every counter is loaded at the same accepted-snapshot edge.
    generate
        for (genvar gi = 0; gi < NUM_COUNTERS; gi++) begin : g_shadow
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shadow_reg[gi] <= '0;
                end else if (load_shadow) begin
                    shadow_reg[gi] <= counters_flat[32*gi +: 32];
                end
            end
        end
    endgenerate

    // Select the data byte that will be presented after the next handshake.
    always_comb begin
        sel_idx      = (state_reg == DATA) ? byte_idx_reg + 1'b1 : '0;
        sel_word_idx = sel_idx[IDX_W-1:2];
        sel_word     = (int'(sel_word_idx) < NUM_COUNTERS) ? shadow_reg[sel_word_idx] : 32'h0;
        case (sel_idx[1:0])
            2'd0:    sel_byte = sel_word[31:24];
            2'd1:    sel_byte = sel_word[23:16];
            2'd2:    sel_byte = sel_word[15:8];
            default: sel_byte = sel_word[7:0];
        endcase
    end

    // Frame FSM: next state and next registered byte output.
    always_comb begin
        state_next    = state_reg;
        byte_idx_next = byte_idx_reg;
        tx_data_next  = tx_data_reg;
        tx_valid_next = tx_valid_reg;
        load_shadow   = 1'b0;
        frame_done    = 1'b0;
`ifdef PROFILER_REPORT_CHECKSUM_EN
        csum_next     = csum_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (snapshot_req) begin
                    load_shadow   = 1'b1;
                    state_next    = HEADER;
                    tx_valid_next = 1'b1;
                    tx_data_next  = HEADER_BYTE;
`ifdef PROFILER_REPORT_CHECKSUM_EN
                    csum_next     = 8'h00;
`endif
                end
            end
            HEADER: begin
                if (handshake) begin
                    state_next   = COUNT;
                    tx_data_next = COUNT_BYTE;
                end
            end
            COUNT: begin
                if (handshake) begin
                    state_next    = DATA;
                    byte_idx_next = '0;
                    tx_data_next  = sel_byte;
`ifdef PROFILER_REPORT_CHECKSUM_EN
                    csum_next     = csum_reg + tx_data_reg;
`endif
                end
            end
            DATA: begin
                if (handshake) begin
`ifdef PROFILER_REPORT_CHECKSUM_EN
                    csum_next = csum_reg + tx_data_reg;
`endif
                    if (byte_idx_reg == LAST_IDX) begin
`ifdef PROFILER_REPORT_CHECKSUM_EN
                        state_next   = CSUM;
                        tx_data_next = csum_reg + tx_data_reg;
`else
                        state_next    = IDLE;
                        tx_valid_next = 1'b0;
                        tx_data_next  = 8'h00;
                        frame_done    = 1'b1;
`endif
                    end else begin
                        byte_idx_next = byte_idx_reg + 1'b1;
                        tx_data_next  = sel_byte;
                    end
                end
            end
`ifdef PROFILER_REPORT_CHECKSUM_EN
            CSUM: begin
                if (handshake) begin
                    state_next    = IDLE;
                    tx_valid_next = 1'b0;
                    tx_data_next  = 8'h00;
                    frame_done    = 1'b1;
                end
            end
`endif
            default: begin
                state_next    = IDLE;
                tx_valid_next = 1'b0;
            end
        endcase
    end

    // FSM and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            byte_idx_reg <= '0;
            tx_data_reg  <= 8'h00;
            tx_valid_reg <= 1'b0;
`ifdef PROFILER_REPORT_CHECKSUM_EN
            csum_reg     <= 8'h00;
`endif
        end else begin
            state_reg    <= state_next;
            byte_idx_reg <= byte_idx_next;
            tx_data_reg  <= tx_data_next;
            tx_valid_reg <= tx_valid_next;
`ifdef PROFILER_REPORT_CHECKSUM_EN
            csum_reg     <= csum_next;
`endif
        end
    end

    // Frame counter (wrapping) and saturating count of requests dropped while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count_reg   <= 16'h0000;
            overrun_count_reg <= 8'h00;
        end else begin
            if (frame_done) begin
                frame_count_reg <= frame_count_reg + 16'h0001;
            end
            if (snapshot_req && busy && (overrun_count_reg != 8'hFF)) begin
                overrun_count_reg <= overrun_count_reg + 8'h01;
            end
        end
    end

endmodule

// File: tb/tb_profile_report_streamer.sv
// Scoreboard bench for profile_report_streamer. Expected frame bytes are
// built from the counter values at each snapshot and queued; the monitor
// pops and compares one entry per handshake. Checksum expectations follow
// PROFILER_REPORT_CHECKSUM_EN.
module tb_profile_report_streamer;

    localparam int NC = 11;
    localparam int BUDGET = 3000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              snapshot_req = 1'b0;
    logic [NC*32-1:0]  counters_flat = '0;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b1;
    logic              busy;
    logic [15:0]       frame_count;
    logic [7:0]        overrun_count;

    logic [7:0] exp_q [$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_pop = 0;
    bit         bp_mode = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    profile_report_streamer #(
        .NUM_COUNTERS (NC),
        .HEADER_BYTE  (8'hA5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .snapshot_req  (snapshot_req),
        .counters_flat (counters_flat),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .frame_count   (frame_count),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame built straight from the current counter inputs.
    task automatic push_frame();
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'h00;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(NC));
        sum = sum + 8'(NC);
        for (int i = 0; i < NC; i++) begin
            for (int k = 3; k >= 0; k--) begin
                b = counters_flat[32*i + 8*k +: 8];
                exp_q.push_back(b);
                sum = sum + b;
            end
        end
`ifdef PROFILER_REPORT_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
    endtask

    // Called in the slot just after a rising edge; request is sampled at the next edge.
    task automatic start_frame();
        snapshot_req = 1'b1;
        push_frame();
        @(posedge clk); #1;
        snapshot_req = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || busy) && c < BUDGET) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= BUDGET) check({tag, "_timeout_left"}, exp_q.size(), 0);
        check({tag, "_busy_end"}, busy, 1'b0);
        check({tag, "_valid_end"}, tx_valid, 1'b0);
    endtask

    // Sink readiness: always ready, or pseudo-random backpressure.
    initial begin
        forever begin
            @(posedge clk); #1;
            tx_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: handshake seen at the falling edge completes at the next rising edge.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) check("hold_stable", tx_data, prev_data);
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_byte_valid", tx_valid, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        $display("byte %0d: got %02h exp %02h", n_pop, tx_data, e);
                        check("byte", tx_data, e);
                        n_pop++;
                    end
                end
            end
        end
    end

    initial begin
        int base;
        int c;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_frame_count", frame_count, 16'h0);
        check("rst_overrun", overrun_count, 8'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Basic frame
        counters_flat = '0;
        counters_flat[31:0] = 32'h11223344;
        start_frame();
        check("first_valid", tx_valid, 1'b1);
        check("first_busy", busy, 1'b1);
        check("first_header", tx_data, 8'hA5);
        wait_done("basic");
        check("basic_frame_count", frame_count, 16'd1);

        // Backpressure
        bp_mode = 1'b1;
        start_frame();
        wait_done("bp");
        bp_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("bp_frame_count", frame_count, 16'd2);

        // Snapshot isolation
        counters_flat[32*10 +: 32] = 32'h00000005;
        start_frame();
        counters_flat[32*10 +: 32] = 32'hFFFFFFFF;
        wait_done("iso");
        check("iso_frame_count", frame_count, 16'd3);

        // Overrun: mid-frame request and request at the final handshake
        repeat (2) @(posedge clk);
        #1;
        base = n_pop;
        start_frame();
        c = 0;
        while (n_pop < base + 10 && c < BUDGET) begin
            @(posedge clk); #1;
            c++;
        end
        check("ovr_mid_busy", busy, 1'b1);
        snapshot_req = 1'b1;
        @(posedge clk); #1;
        snapshot_req = 1'b0;
        check("ovr_count_1", overrun_count, 8'd1);
        c = 0;
        while (exp_q.size() != 1 && c < BUDGET) begin
            @(posedge clk); #1;
            c++;
        end
        check("ovr_last_left", exp_q.size(), 1);
        snapshot_req = 1'b1;
        @(posedge clk); #1;
        snapshot_req = 1'b0;
        check("ovr_busy_after_last", busy, 1'b0);
        check("ovr_valid_after_last", tx_valid, 1'b0);
        check("ovr_count_2", overrun_count, 8'd2);
        check("ovr_frame_count", frame_count, 16'd4);
        start_frame();
        check("ovr_restart_busy", busy, 1'b1);
        wait_done("ovr2");
        check("ovr2_frame_count", frame_count, 16'd5);
        check("ovr2_overrun", overrun_count, 8'd2);

        // Reset mid-frame
        base = n_pop;
        start_frame();
        c = 0;
        while (n_pop < base + 20 && c < BUDGET) begin
            @(posedge clk); #1;
            c++;
        end
        rst = 1'b1;
        #1;
        check("midrst_valid", tx_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_frame_count", frame_count, 16'd0);
        check("midrst_overrun", overrun_count, 8'd0);
        exp_q.delete();
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("postrst_valid", tx_valid, 1'b0);
        start_frame();
        wait_done("postrst");
        check("postrst_frame_count", frame_count, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
